rx_sync_ctrl_module: RTL
========================

RX_SYNC_CTRL_MODULE -- requirements
Module: rx_sync_ctrl_module

Interface
REQ-001 Parameter: SLOT_CYCLES, default 16'd2000, slot length in logic_clk_in cycles; legal range 2..65535.
REQ-002 logic_clk_in  input  1  200MHz logic clock; all logic on rising edge.
REQ-003 logic_rst_in  input  1  reset; asynchronous, active-high.
REQ-004 coarse_syn_success_in  input  1  coarse SYNC correlation success pulse from the decision stage.
REQ-005 coarse_position_in  input  5  coarse position accompanying the success pulse.
REQ-006 tr_syn_success_in  input  1  TR sync success, qualified by tr_syn_finish_in.
REQ-007 tr_syn_finish_in  input  1  TR sync attempt complete, one-cycle pulse.
REQ-008 tr_position_in  input  7  TR position, valid with tr_syn_finish_in.
REQ-009 tr_wait_cycles_in  input  16  delay from coarse success to TR window.
REQ-010 tr_timeout_in  input  16  TR window limit in cycles; 0 means no timeout.
REQ-011 resync_req_in  input  1  forces return to search.
REQ-012 tr_syn_en_out  output  1  TR sync enable to the decision stage.
REQ-013 sync_state_out  output  2  current state encoding.
REQ-014 sync_locked_out  output  1  high in LOCKED.
REQ-015 slot_start_out  output  1  one-cycle pulse per slot boundary while locked.
REQ-016 slot_offset_out  output  12  {latched coarse position[4:0], latched TR position[6:0]}.
REQ-017 fail_count_out  output  8  saturating count of failed TR attempts.
REQ-018 debug_signal  output  64  debug bus.

Function
REQ-019 The block SHALL implement four states: SEARCH=2'd0, TR_WAIT=2'd1, TR_SYNC=2'd2, LOCKED=2'd3. sync_state_out SHALL equal the registered state.
REQ-020 SEARCH: coarse_syn_success_in=1 SHALL move to TR_WAIT next cycle, load wait counter with tr_wait_cycles_in, latch coarse_position_in.
REQ-021 TR_WAIT: counter decrements each cycle; at counter==0 SHALL move to TR_SYNC next cycle (tr_wait_cycles_in=0 gives exactly one TR_WAIT cycle); coarse pulses ignored.
REQ-022 tr_syn_en_out SHALL be a registered level, 1 exactly while state==TR_SYNC.
REQ-023 TR_SYNC: timeout counter starts at 0 on entry and increments each cycle, saturating at 16'hFFFF.
REQ-024 TR_SYNC with tr_syn_finish_in=1 and tr_syn_success_in=1 SHALL move to LOCKED and latch tr_position_in.
REQ-025 TR_SYNC with tr_syn_finish_in=1 and tr_syn_success_in=0 SHALL move to SEARCH and increment fail_count_out.
REQ-026 TR_SYNC with tr_timeout_in!=0 and timeout counter==tr_timeout_in-1 and no finish SHALL move to SEARCH and increment fail_count_out; finish in the same cycle takes priority.
REQ-027 fail_count_out SHALL saturate at 8'd255.
REQ-028 LOCKED: slot counter SHALL run 0..SLOT_CYCLES-1 and wrap; slot_start_out=1 when counter==0; first pulse on the first LOCKED cycle.
REQ-029 sync_locked_out SHALL be 1 exactly while state==LOCKED; slot_offset_out SHALL hold its latched value until the next lock.
REQ-030 resync_req_in=1 in any state SHALL move to SEARCH next cycle, clearing wait, timeout and slot counters; it overrides every other event in the same cycle; fail_count_out is unchanged.
REQ-031 tr_syn_finish_in outside TR_SYNC SHALL be ignored.

Reset
REQ-032 While logic_rst_in=1: state=SEARCH; all counters, tr_syn_en_out, sync_locked_out, slot_start_out=0; slot_offset_out=12'd0; fail_count_out=8'd0; debug_signal=64'd0.
REQ-033 Reset asserted mid-operation SHALL abort immediately (asynchronously) to the reset values; the first transition occurs on the first edge after deassertion.

Configuration
REQ-034 Macro RX_SYNC_CTRL_DEBUG_EN defined: debug_signal = {slot counter[15:0], timeout counter[15:0], wait counter[15:0], fail_count_out[7:0], 3'd0, resync_req_in, tr_syn_finish_in, coarse_syn_success_in, sync_state_out[1:0]}, registered.
REQ-035 Macro undefined: debug_signal tied to 64'd0, no debug registers.

Verification
REQ-036 Reset, coarse pulse pos=5'd7, wait=16'd3, TR finish+success pos=7'd42 after 10 TR cycles -> TR_WAIT 4 cycles, tr_syn_en_out high 10 cycles, LOCKED, slot_offset_out=12'h3AA, slot_start_out pulse every 2000 cycles.
REQ-037 TR finish with success=0 -> SEARCH, fail_count_out=1; repeat 300 times -> fail_count_out stays 255.
REQ-038 tr_timeout_in=16'd5, no finish -> tr_syn_en_out high exactly 5 cycles, then SEARCH, fail_count_out increments; with tr_timeout_in=0 -> stays in TR_SYNC for 70000 cycles.
REQ-039 Finish+success on the timeout cycle -> LOCKED, no fail increment; resync_req_in with finish same cycle -> SEARCH.
REQ-040 Assert logic_rst_in mid-LOCKED between clock edges -> outputs zero without waiting for an edge; coarse pulse in TR_WAIT or finish in SEARCH -> no effect.

Source files
------------

// File: rtl/rx_sync_ctrl_module.sv
// rx_sync_ctrl_module: receive synchronisation sequencer.
// It takes a coarse SYNC hit, waits a programmable delay, opens a TR sync
// window with an optional timeout, and then tracks slot boundaries while locked.
// Optional build macro RX_SYNC_CTRL_DEBUG_EN adds a registered debug bus.
// Without the macro, debug_signal is tied to zero.
//
// state   | meaning
// SEARCH  | waiting for a coarse SYNC success pulse
// TR_WAIT | counting down the delay before the TR sync window
// TR_SYNC | TR sync window open (tr_syn_en_out high), timeout running
// LOCKED  | synchronised, slot counter running
module rx_sync_ctrl_module #(
  parameter logic [15:0] SLOT_CYCLES = 16'd2000
) (
  input  logic        logic_clk_in,
  input  logic        logic_rst_in,
  input  logic        coarse_syn_success_in,
  input  logic [4:0]  coarse_position_in,
  input  logic        tr_syn_success_in,
  input  logic        tr_syn_finish_in,
  input  logic [6:0]  tr_position_in,
  input  logic [15:0] tr_wait_cycles_in,
  input  logic [15:0] tr_timeout_in,
  input  logic        resync_req_in,
  output logic        tr_syn_en_out,
  output logic [1:0]  sync_state_out,
  output logic        sync_locked_out,
  output logic        slot_start_out,
  output logic [11:0] slot_offset_out,
  output logic [7:0]  fail_count_out,
  output logic [63:0] debug_signal
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TR_WAIT = 2'd1,
    TR_SYNC = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
  logic [15:0] slot_cnt, slot_cnt_nxt;
  logic [4:0]  coarse_pos, coarse_pos_nxt;
  logic [11:0] offset, offset_nxt;
  logic [7:0]  fail_cnt, fail_cnt_nxt;
  logic        tmo_hit;

  // A zero limit disables the timeout entirely.
  assign tmo_hit = (tr_timeout_in != 16'd0) && (tmo_cnt == (tr_timeout_in - 16'd1));

  // Next-state and counter update logic; resync overrides everything last.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    slot_cnt_nxt   = slot_cnt;
    coarse_pos_nxt = coarse_pos;
    offset_nxt     = offset;
    fail_cnt_nxt   = fail_cnt;

    case (state)
      SEARCH: begin
        if (coarse_syn_success_in) begin
          state_nxt      = TR_WAIT;
          wait_cnt_nxt   = tr_wait_cycles_in;
          coarse_pos_nxt = coarse_position_in;
        end
      end
      TR_WAIT: begin
        if (wait_cnt == 16'd0) begin
          state_nxt   = TR_SYNC;
          tmo_cnt_nxt = 16'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 16'd1;
        end
      end
      TR_SYNC: begin
        if (tr_syn_finish_in) begin
          if (tr_syn_success_in) begin
            state_nxt    = LOCKED;
            offset_nxt   = {coarse_pos, tr_position_in};
            slot_cnt_nxt = 16'd0;
          end else begin
            state_nxt    = SEARCH;
            fail_cnt_nxt = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
          end
        end else if (tmo_hit) begin
          state_nxt    = SEARCH;
          fail_cnt_nxt = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
        end else begin
          tmo_cnt_nxt = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
        end
      end
      LOCKED: begin
        slot_cnt_nxt = (slot_cnt == (SLOT_CYCLES - 16'd1)) ? 16'd0 : slot_cnt + 16'd1;
      end
      default: state_nxt = SEARCH;
    endcase

    if (resync_req_in) begin
      state_nxt      = SEARCH;
      wait_cnt_nxt   = 16'd0;
      tmo_cnt_nxt    = 16'd0;
      slot_cnt_nxt   = 16'd0;
      coarse_pos_nxt = coarse_pos;
      offset_nxt     = offset;
      fail_cnt_nxt   = fail_cnt;
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      state           <= SEARCH;
      wait_cnt        <= 16'd0;
      tmo_cnt         <= 16'd0;
      slot_cnt        <= 16'd0;
      coarse_pos      <= 5'd0;
      offset          <= 12'd0;
      fail_cnt        <= 8'd0;
      tr_syn_en_out   <= 1'b0;
      sync_locked_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_cnt_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      slot_cnt        <= slot_cnt_nxt;
      coarse_pos      <= coarse_pos_nxt;
      offset          <= offset_nxt;
      fail_cnt        <= fail_cnt_nxt;
      tr_syn_en_out   <= (state_nxt == TR_SYNC);
      sync_locked_out <= (state_nxt == LOCKED);
    end
  end

  assign sync_state_out  = state;
  assign slot_start_out  = (state == LOCKED) && (slot_cnt == 16'd0);
  assign slot_offset_out = offset;
  assign fail_count_out  = fail_cnt;

`ifdef RX_SYNC_CTRL_DEBUG_EN
  logic [63:0] debug_q;

  // Snapshot of internal counters and event inputs, one cycle late.
  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      debug_q <= 64'd0;
    end else begin
      debug_q <= {slot_cnt, tmo_cnt, wait_cnt, fail_cnt, 3'd0,
                  resync_req_in, tr_syn_finish_in, coarse_syn_success_in, state};
    end
  end

  assign debug_signal = debug_q;
`else
  assign debug_signal = 64'd0;
`endif

endmodule
